// File: rtl/islemci_pkg.sv
// Shared definitions for the islemci bus processor: opcodes, FSM state encoding
// and the register-index width helper.
package islemci_pkg;

    localparam logic [3:0] OP_MV   = 4'd0;
    localparam logic [3:0] OP_MVI  = 4'd1;
    localparam logic [3:0] OP_ADD  = 4'd2;
    localparam logic [3:0] OP_SUB  = 4'd3;
    localparam logic [3:0] OP_AND  = 4'd4;
    localparam logic [3:0] OP_OR   = 4'd5;
    localparam logic [3:0] OP_XOR  = 4'd6;
    localparam logic [3:0] OP_MVNZ = 4'd7;

    typedef enum logic [1:0] {
        T0 = 2'd0,
        T1 = 2'd1,
        T2 = 2'd2,
        T3 = 2'd3
    } state_t;

    // Number of bits needed to index nregs registers (nregs is a power of two).
    function automatic int f_rw(input int nregs);
        int rw;
        rw = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < nregs) begin
                rw = i + 1;
            end
        end
        return rw;
    endfunction

endpackage

// File: rtl/islemci_alu.sv
// Combinational ALU for the islemci processor: add, sub, and, or, xor on A and
// the bus operand B; arithmetic wraps modulo 2^WIDTH.
module islemci_alu
    import islemci_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       op,
    output logic [WIDTH-1:0] result
);

    always_comb begin
        result = '0;
        case (op)
            OP_ADD:  result = A + B;
            OP_SUB:  result = A - B;
            OP_AND:  result = A & B;
            OP_OR:   result = A | B;
            OP_XOR:  result = A ^ B;
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/islemci_param.sv
// Multicycle bus processor: NREGS registers, A and G registers and a zero flag
// share one bus; each instruction is fetched in T0 and retires in T1 or T3.
module islemci_param
    import islemci_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int NREGS = 8
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic [WIDTH-1:0] DIN,
    input  logic             Run,
    output logic             Done,
    output logic             Err,
    output logic             Zflag,
    output logic [WIDTH-1:0] BusWires
);

    localparam int RW = f_rw(NREGS);

    state_t           r_state;
    state_t           w_state_next;
    logic [3:0]       r_op;
    logic [RW-1:0]    r_x;
    logic [RW-1:0]    r_y;
    logic [WIDTH-1:0] r_regs [NREGS];
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_g;
    logic             r_z;

    logic [3:0]       w_din_op;
    logic [RW-1:0]    w_din_x;
    logic [RW-1:0]    w_din_y;
    logic [WIDTH-1:0] w_alu_res;
    logic             w_is_alu;
    logic             w_is_illegal;
    logic             w_ld_ir;
    logic             w_ld_a;
    logic             w_ld_g;
    logic             w_wr_en;
    logic [NREGS-1:0] w_wr_sel;

    assign w_din_op     = DIN[WIDTH-1 -: 4];
    assign w_din_x      = DIN[WIDTH-5 -: RW];
    assign w_din_y      = DIN[WIDTH-5-RW -: RW];
    assign w_is_alu     = (r_op >= OP_ADD) && (r_op <= OP_XOR);
    assign w_is_illegal = r_op[3];
    assign Zflag        = r_z;

    always_comb begin
        w_state_next = r_state;
        w_ld_ir      = 1'b0;
        w_ld_a       = 1'b0;
        w_ld_g       = 1'b0;
        w_wr_en      = 1'b0;
        Done         = 1'b0;
        Err          = 1'b0;
        case (r_state)
            T0: begin
                if (Run) begin
                    w_ld_ir      = 1'b1;
                    w_state_next = T1;
                end
            end
            T1: begin
                if (w_is_alu) begin
                    w_ld_a       = 1'b1;
                    w_state_next = T2;
                end else begin
                    Done         = 1'b1;
                    Err          = w_is_illegal;
                    w_state_next = T0;
                    // mvnz only commits when the last ALU result was non-zero
                    w_wr_en      = (r_op == OP_MV) || (r_op == OP_MVI) ||
                                   ((r_op == OP_MVNZ) && !r_z);
                end
            end
            T2: begin
                w_ld_g       = 1'b1;
                w_state_next = T3;
            end
            T3: begin
                Done         = 1'b1;
                w_wr_en      = 1'b1;
                w_state_next = T0;
            end
            default: w_state_next = T0;
        endcase
    end

    always_comb begin
        BusWires = DIN;
        case (r_state)
            T1: begin
                if (w_is_alu) begin
                    BusWires = r_regs[r_x];
                end else if ((r_op == OP_MV) || (r_op == OP_MVNZ)) begin
                    BusWires = r_regs[r_y];
                end
            end
            T2:      BusWires = r_regs[r_y];
            T3:      BusWires = r_g;
            default: BusWires = DIN;
        endcase
    end

    islemci_alu #(
        .WIDTH(WIDTH)
    ) u_alu (
        .A     (r_a),
        .B     (BusWires),
        .op    (r_op),
        .result(w_alu_res)
    );

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_state <= T0;
            r_op    <= '0;
            r_x     <= '0;
            r_y     <= '0;
            r_a     <= '0;
            r_g     <= '0;
            r_z     <= 1'b1;
        end else begin
            r_state <= w_state_next;
            if (w_ld_ir) begin
                r_op <= w_din_op;
                r_x  <= w_din_x;
                r_y  <= w_din_y;
            end
            if (w_ld_a) begin
                r_a <= BusWires;
            end
            if (w_ld_g) begin
                r_g <= w_alu_res;
                r_z <= (w_alu_res == '0);
            end
        end
    end

    // Every register write takes its data from the bus, addressed by IR.X.
    genvar gi;
    generate
        for (gi = 0; gi < NREGS; gi++) begin : g_rf
            assign w_wr_sel[gi] = w_wr_en && (r_x == RW'(gi));
            always_ff @(posedge Clock or posedge Reset) begin
                if (Reset) begin
                    r_regs[gi] <= '0;
                end else if (w_wr_sel[gi]) begin
                    r_regs[gi] <= BusWires;
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_islemci_param.sv
// Scoreboard bench for islemci_param: directed scenarios plus random programs
// checked against an instruction-level reference model.
module tb_islemci_param;

    localparam int WIDTH = 16;
    localparam int NREGS = 8;
    localparam int RW    = $clog2(NREGS);

    typedef logic [WIDTH-1:0] word_t;
    typedef struct {
        word_t bus;
        logic  err;
        logic  z;
        int    cyc;
        string name;
    } exp_t;

    logic  Clock = 1'b0;
    logic  Reset = 1'b1;
    logic  Run   = 1'b0;
    word_t DIN   = '0;
    logic  Done;
    logic  Err;
    logic  Zflag;
    word_t BusWires;

    islemci_param #(
        .WIDTH(WIDTH),
        .NREGS(NREGS)
    ) dut (
        .Clock   (Clock),
        .Reset   (Reset),
        .DIN     (DIN),
        .Run     (Run),
        .Done    (Done),
        .Err     (Err),
        .Zflag   (Zflag),
        .BusWires(BusWires)
    );

    always #5 Clock = ~Clock;

    int cyc = 0;
    always @(posedge Clock) cyc <= cyc + 1;

    exp_t  exp_q[$];
    word_t m_r[NREGS];
    logic  m_z;
    int    n_chk  = 0;
    int    n_fail = 0;
    bit    mon_en = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic string op_name(input int op);
        case (op)
            0: return "mv";
            1: return "mvi";
            2: return "add";
            3: return "sub";
            4: return "and";
            5: return "or";
            6: return "xor";
            7: return "mvnz";
            default: return "ill";
        endcase
    endfunction

    function automatic word_t model_alu(input int op, input word_t a, input word_t b);
        case (op)
            2: return a + b;
            3: return a - b;
            4: return a & b;
            5: return a | b;
            6: return a ^ b;
            default: return '0;
        endcase
    endfunction

    function automatic word_t make_instr(input int op, input int x, input int y);
        word_t w;
        w = word_t'($urandom);
        w[WIDTH-1 -: 4]       = op[3:0];
        w[WIDTH-5 -: RW]      = x[RW-1:0];
        w[WIDTH-5-RW -: RW]   = y[RW-1:0];
        return w;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NREGS; i++) m_r[i] = '0;
        m_z = 1'b1;
    endtask

    // Fetch one instruction, push its expected Done-cycle response, drive T1..T3.
    task automatic issue(input int op, input int x, input int y, input word_t t1_din);
        exp_t  e;
        word_t res;
        bit    is_alu;
        is_alu = (op >= 2) && (op <= 6);
        @(negedge Clock);
        DIN = make_instr(op, x, y);
        Run = 1'b1;
        @(posedge Clock);
        #1;
        e.cyc  = cyc;
        e.err  = 1'b0;
        e.z    = m_z;
        e.name = op_name(op);
        if (op >= 8) begin
            e.err = 1'b1;
            e.bus = t1_din;
        end else if (op == 0) begin
            e.bus = m_r[y];
            m_r[x] = m_r[y];
        end else if (op == 1) begin
            e.bus = t1_din;
            m_r[x] = t1_din;
        end else if (op == 7) begin
            e.bus = m_r[y];
            if (!m_z) m_r[x] = m_r[y];
        end else begin
            res    = model_alu(op, m_r[x], m_r[y]);
            m_z    = (res == '0);
            e.z    = m_z;
            e.bus  = res;
            e.cyc  = cyc + 2;
            m_r[x] = res;
        end
        exp_q.push_back(e);
        DIN = t1_din;
        Run = 1'($urandom_range(0, 1));
        @(posedge Clock);
        if (is_alu) begin
            for (int k = 0; k < 2; k++) begin
                #1;
                DIN = word_t'($urandom);
                Run = 1'($urandom_range(0, 1));
                @(posedge Clock);
            end
        end
    endtask

    always @(negedge Clock) begin : monitor
        exp_t e;
        if (mon_en && !Reset) begin
            if (Done) begin
                if (exp_q.size() == 0) begin
                    check("done_while_idle", 64'(Done), 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check({e.name, "_done_cycle"}, 64'(cyc), 64'(e.cyc));
                    check({e.name, "_bus"}, 64'(BusWires), 64'(e.bus));
                    check({e.name, "_err"}, 64'(Err), 64'(e.err));
                    check({e.name, "_zflag"}, 64'(Zflag), 64'(e.z));
                    $display("txn %-4s bus=%h err=%b z=%b cyc=%0d", e.name, BusWires, Err, Zflag, cyc);
                end
            end else if (Err) begin
                check("err_without_done", 64'(Err), 64'd0);
            end
        end
    end

    initial begin : stimulus
        int    r;
        int    op;
        word_t imm;
        int    drain;
        model_reset();

        // Reset state
        DIN   = word_t'($urandom);
        Reset = 1'b1;
        repeat (2) @(negedge Clock);
        check("rst_done", 64'(Done), 64'd0);
        check("rst_err", 64'(Err), 64'd0);
        check("rst_zflag", 64'(Zflag), 64'd1);
        check("rst_bus_is_din", 64'(BusWires), 64'(DIN));
        Reset  = 1'b0;
        mon_en = 1'b1;

        // Directed scenarios
        issue(1, 1, 0, word_t'(5));
        issue(1, 2, 0, word_t'(3));
        issue(2, 1, 2, word_t'($urandom));      // R1 = 8
        issue(3, 1, 1, word_t'($urandom));      // R1 = 0, Z = 1
        issue(7, 3, 2, word_t'($urandom));      // blocked
        issue(0, 3, 3, word_t'($urandom));      // observe R3 = 0
        issue(4, 2, 2, word_t'($urandom));      // G = 3, Z = 0
        issue(7, 3, 2, word_t'($urandom));      // R3 = 3
        issue(0, 3, 3, word_t'($urandom));
        issue(1, 1, 0, word_t'(16'hFFFF));
        issue(1, 2, 0, word_t'(1));
        issue(2, 1, 2, word_t'($urandom));      // wraps to 0, Z = 1
        issue(1, 4, 0, word_t'(16'hF0F0));
        issue(1, 5, 0, word_t'(16'h0FF0));
        issue(6, 4, 5, word_t'($urandom));      // FF00
        issue(1, 4, 0, word_t'(16'hF0F0));
        issue(5, 4, 5, word_t'($urandom));      // FFF0
        issue(10, 4, 5, word_t'($urandom));     // illegal
        issue(0, 4, 4, word_t'($urandom));
        issue(2, 5, 5, word_t'($urandom));      // doubling
        issue(1, 7, 0, word_t'(16'h00A5));
        issue(6, 7, 7, word_t'($urandom));

        // Reset during T2 and T3 of an add aborts without Done or write
        for (int d = 1; d <= 2; d++) begin
            issue(1, 5, 0, word_t'(16'h1230 + d));
            @(negedge Clock);
            DIN = make_instr(2, 5, 5);
            Run = 1'b1;
            @(posedge Clock);
            repeat (d) @(posedge Clock);
            #1;
            Reset = 1'b1;
            Run   = 1'b0;
            @(negedge Clock);
            check("midrst_done", 64'(Done), 64'd0);
            check("midrst_bus_is_din", 64'(BusWires), 64'(DIN));
            check("midrst_zflag", 64'(Zflag), 64'd1);
            @(negedge Clock);
            Reset = 1'b0;
            model_reset();
            issue(0, 5, 5, word_t'($urandom));
            issue(0, 1, 1, word_t'($urandom));
        end

        // Random programs
        for (int n = 0; n < 250; n++) begin
            r = $urandom_range(0, 19);
            if (r < 2) begin
                @(negedge Clock);
                Run = 1'b0;
                DIN = word_t'($urandom);
                @(posedge Clock);
            end else begin
                op  = (r < 4) ? $urandom_range(8, 15) : $urandom_range(0, 7);
                imm = word_t'($urandom);
                if (r == 19) imm = '0;
                if (r == 18) imm = '1;
                issue(op, $urandom_range(0, NREGS - 1), $urandom_range(0, NREGS - 1), imm);
            end
        end

        // Read back every register
        for (int i = 0; i < NREGS; i++) begin
            issue(0, i, i, word_t'($urandom));
        end

        @(negedge Clock);
        Run   = 1'b0;
        drain = 0;
        while (exp_q.size() != 0 && drain < 10) begin
            @(negedge Clock);
            drain++;
        end
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        repeat (3) @(negedge Clock);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/islemci_param.md
# islemci_param

Parametrised multicycle bus processor: NREGS general registers, an A operand register, a G result register and a zero flag share one WIDTH-bit bus. It fetches one instruction word from DIN when Run is high and executes it in one or three further cycles, pulsing Done at completion. It adds logic ops, a flag-qualified conditional move and illegal-opcode handling to the lab processor datapath. It is the top-level compute block of the lab design.

## Interface
- WIDTH, 16: datapath and instruction word width. Must be ≥ 4 + 2·log2(NREGS).
- NREGS, 8: number of general registers. Must be a power of two, 2..16.
- Clock  in  1  sole clock; all state updates on rising edge.
- Reset  in  1  asynchronous, active-high; clears all state.
- DIN  in  WIDTH  instruction word in T0, immediate data in T1 of mvi.
- Run  in  1  start request, sampled only in T0.
- Done  out  1  high for the final cycle of each instruction.
- Err  out  1  high with Done when the opcode is illegal.
- Zflag  out  1  registered: G == 0.
- BusWires  out  WIDTH  shared bus value.

## Operation
- Instruction fields (RW = log2(NREGS)):
  - op = DIN[WIDTH-1 -: 4]
  - X = next RW bits below op
  - Y = next RW bits below X
  - remaining low bits are ignored.
- Opcodes:
  - 0 mv: RX←RY.
  - 1 mvi: RX←DIN.
  - 2 add: RX←RX+RY.
  - 3 sub: RX←RX−RY.
  - 4 and, 5 or, 6 xor: RX←RX op RY.
  - 7 mvnz: RX←RY only if Zflag==0.
  - 8–15 illegal.
- Arithmetic is modulo 2^WIDTH. No carry is kept. sub is two's-complement.
- Zflag updates only when G is loaded (T2 of ALU ops). mv, mvi and mvnz leave G and Zflag unchanged.
- FSM states: T0, T1, T2, T3.
  - T0 → T1: when Run=1. IR←DIN (op, X, Y only).
  - T0 stays in T0: when Run=0. IR holds.
  - T1 → T0: for mv, mvi, mvnz and illegal ops, with Done=1.
  - T1 → T2: for ALU ops, with A←RX.
  - T2 → T3: G←A op RY, Zflag←(result==0).
  - T3 → T0: RX←G, Done=1.
- Illegal op: Done=1 and Err=1 in T1. No register, G or flag changes.
- Bus source, one-hot priority:
  - T1 of mv and mvnz drive RY.
  - T1 of ALU ops drives RX.
  - T2 drives RY.
  - T3 drives G.
  - All other cycles drive DIN.
- X==Y is legal:
  - add doubles RX.
  - sub and xor give 0 and set Zflag.
  - mv is a no-op write.
- Run is ignored outside T0. If Run is held high, instructions execute back-to-back; the next fetch is in the T0 that follows Done.

## Timing
- Latency from the fetch edge:
  - mv, mvi, mvnz, illegal: 2 cycles (T0, T1).
  - ALU ops: 4 cycles (T0–T3).
- Done and Err are Moore outputs, decoded from state and IR, high for exactly one cycle. The register write commits on the clock edge that ends the Done cycle.
- mvi samples DIN on the edge ending T1. DIN must hold the immediate for all of T1.
- Reset values:
  - state T0, IR 0, all R 0, A 0, G 0, Zflag 1.
  - Done 0, Err 0.
  - BusWires = DIN (combinational, T0 default).
- Reset asserted mid-instruction aborts at once: no Done and no partial write, including in T3.
- The first fetch is possible on the first rising edge after Reset deasserts.

## Structure
- Package islemci_pkg holds:
  - opcode localparams OP_MV … OP_MVNZ;
  - the state encoding T0–T3;
  - a function computing RW from NREGS.
- Sub-module islemci_alu (combinational; WIDTH param): inputs A, B and op; output result.
- The register file, FSM and bus mux stay in islemci_param.

## Test plan
- Reset, then mvi R1 with DIN=0x0005 in T1, then mvi R2 with 0x0003 → R1=5, R2=3. Done is high one cycle each; 2 cycles per instruction.
- add R1,R2 → Done in the 4th cycle, R1=0x0008, Zflag=0. Then sub R1,R1 → R1=0, Zflag=1.
- With Zflag=1, mvnz R3,R2 → R3 unchanged (0). Then and R2,R2 (G=3, Zflag=0), then mvnz R3,R2 → R3=3.
- R1=0xFFFF, R2=1: add R1,R2 → R1=0x0000, Zflag=1. Check xor and or with 0xF0F0 and 0x0FF0 → 0xFF00 and 0xFFF0.
- Opcode 0xA → Done=1 and Err=1 in T1, all registers and Zflag unchanged. Run toggling during T1–T3 has no effect.
- Assert Reset during T2 of an add → state T0, all registers 0, Done never asserted. NREGS=16, WIDTH=24 build passes the mvi/add scenario using R15.
